fp16_to_fixed: RTL

Sequential converter from IEEE-754 half-precision values to signed two's-complement fixed-point. It sits on the output side of the float MAC and consumes the 16-bit sign/exponent/mantissa words that the FP adder stage registers. It turns them into integer/fixed values for downstream integer logic. Mantissa alignment is iterative, one bit per cycle, with valid/ready handshakes on both sides.

---
 rtl/fp16_to_fixed_pkg.sv | 16 +
 rtl/fp16_to_fixed.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fp16_to_fixed_pkg.sv
// Shared FP16 field constants and the converter FSM encoding.
// Imported by the FP16 to fixed-point converter and its bench.
package fp16_to_fixed_pkg;

  localparam int FP16_EXP_W   = 5;
  localparam int FP16_MANT_W  = 10;
  localparam int FP16_BIAS    = 15;
  localparam int FP16_EXP_MAX = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fp16_to_fixed.sv
// FP16 to signed fixed-point converter; the mantissa is aligned one bit per
// cycle, with valid/ready handshakes on both the input and output sides.
module fp16_to_fixed
  import fp16_to_fixed_pkg::*;
#(
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output state_t           state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never waits on ready, and data holds while valid & !ready.

  localparam int               MAG_W    = OUT_W + 1;
  localparam logic signed [7:0] SH_OFS  = 8'(FRAC_W - FP16_BIAS - FP16_MANT_W);
  localparam logic signed [7:0] SH_MIN  = -8'sd11;
  localparam logic signed [7:0] SH_SAT  = 8'(OUT_W - FP16_MANT_W);
  localparam logic [FP16_EXP_W-1:0] EXP_ALL1 = FP16_EXP_W'(FP16_EXP_MAX);
  localparam logic [MAG_W-1:0] HALF     = MAG_W'(1) << (OUT_W - 1);
  localparam logic [MAG_W-1:0] SAT_MAG  = MAG_W'(1) << OUT_W;
  localparam logic [OUT_W-1:0] POS_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

  state_t           state, state_nx;
  logic             sign_q, right_q;
  logic [7:0]       count_q;
  logic [MAG_W-1:0] mag_q;

  logic [FP16_EXP_W-1:0]  e_in;
  logic [FP16_MANT_W-1:0] m_in;
  logic signed [7:0]      sh;
  logic [7:0]             sh_abs;
  logic                   is_zero, is_sat, accept;
  logic [MAG_W-1:0]       mag_init;
  logic [7:0]             count_init;
  logic [OUT_W-1:0]       fin_data;
  logic                   fin_ovf;

  assign e_in   = in_data[14:10];
  assign m_in   = in_data[9:0];
  assign sh     = signed'({3'b000, e_in}) + SH_OFS;
  assign sh_abs = sh[7] ? -sh : sh;

  // Specials never shift: saturation loads a magnitude above 2^(OUT_W-1) so
  // the normal finish logic clamps it toward the sign and flags overflow.
  assign is_zero = (e_in == '0) || (e_in == EXP_ALL1 && m_in != '0) ||
                   (e_in != EXP_ALL1 && sh <= SH_MIN);
  assign is_sat  = (e_in == EXP_ALL1 && m_in == '0) ||
                   (e_in != EXP_ALL1 && sh >= SH_SAT);

  assign mag_init   = is_zero ? '0 : (is_sat ? SAT_MAG : MAG_W'({1'b1, m_in}));
  assign count_init = (is_zero || is_sat) ? 8'd0 : sh_abs;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid & in_ready;
  assign state_dbg = state;

  always_comb begin
    fin_data = sign_q ? OUT_W'(-mag_q) : mag_q[OUT_W-1:0];
    fin_ovf  = 1'b0;
    if (!sign_q && mag_q >= HALF) begin
      fin_data = POS_MAX;
      fin_ovf  = 1'b1;
    end else if (sign_q && mag_q > HALF) begin
      fin_data = NEG_MIN;
      fin_ovf  = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (in_valid)        state_nx = ST_SHIFT;
      ST_SHIFT: if (count_q == 8'd0) state_nx = ST_DONE;
      ST_DONE:  if (out_ready)       state_nx = ST_IDLE;
      default:                       state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sign_q   <= 1'b0;
      right_q  <= 1'b0;
      count_q  <= 8'd0;
      mag_q    <= '0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (accept) begin
      sign_q  <= in_data[15];
      right_q <= sh[7];
      count_q <= count_init;
      mag_q   <= mag_init;
    end else if (state == ST_SHIFT) begin
      if (count_q != 8'd0) begin
        mag_q   <= right_q ? (mag_q >> 1) : (mag_q << 1);
        count_q <= count_q - 8'd1;
      end else begin
        out_data <= fin_data;
        out_ovf  <= fin_ovf;
      end
    end
  end

endmodule
